// File: rtl/gray_counter.sv
// Registered binary/Gray up/down counter with synchronous load and wrap-or-saturate limits.
// o_bin and o_gray are loaded on the same edge, so they always describe the same count.
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_sat,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_bin,
  output logic [WIDTH-1:0] o_bin,
  output logic [WIDTH-1:0] o_gray,
  output logic             o_wrap,
  output logic             o_sat_hit
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MIN_VAL = '0;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_sat_hit;

  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_wrap;
  logic             w_sat_hit;

  // Next count: load beats counting; a step at a limit either wraps or is blocked.
  always_comb begin
    w_next_bin = r_bin;
    w_wrap     = 1'b0;
    w_sat_hit  = 1'b0;
    if (i_load) begin
      w_next_bin = i_load_bin;
    end else if (i_en) begin
      if (i_up) begin
        if (r_bin != MAX_VAL) begin
          w_next_bin = r_bin + WIDTH'(1);
        end else if (i_sat) begin
          w_sat_hit = 1'b1;
        end else begin
          w_next_bin = MIN_VAL;
          w_wrap     = 1'b1;
        end
      end else begin
        if (r_bin != MIN_VAL) begin
          w_next_bin = r_bin - WIDTH'(1);
        end else if (i_sat) begin
          w_sat_hit = 1'b1;
        end else begin
          w_next_bin = MAX_VAL;
          w_wrap     = 1'b1;
        end
      end
    end
    w_next_gray = w_next_bin ^ (w_next_bin >> 1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin     <= '0;
      r_gray    <= '0;
      r_wrap    <= 1'b0;
      r_sat_hit <= 1'b0;
    end else begin
      r_bin     <= w_next_bin;
      r_gray    <= w_next_gray;
      r_wrap    <= w_wrap;
      r_sat_hit <= w_sat_hit;
    end
  end

  assign o_bin     = r_bin;
  assign o_gray    = r_gray;
  assign o_wrap    = r_wrap;
  assign o_sat_hit = r_sat_hit;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: directed vector table at WIDTH=4, hand sequences, and a
// WIDTH=8 random run against a behavioural model.
module tb_gray_counter;

  logic       clk;
  logic       rst, en, up, sat, load;
  logic [3:0] load_bin;
  logic [3:0] bin4, gray4;
  logic       wrap4, sath4;

  logic       rst8, en8, up8, sat8, load8;
  logic [7:0] load_bin8;
  logic [7:0] bin8, gray8;
  logic       wrap8, sath8;

  int total = 0;
  int bad   = 0;

  gray_counter #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_sat(sat),
    .i_load(load), .i_load_bin(load_bin),
    .o_bin(bin4), .o_gray(gray4), .o_wrap(wrap4), .o_sat_hit(sath4)
  );

  gray_counter #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_en(en8), .i_up(up8), .i_sat(sat8),
    .i_load(load8), .i_load_bin(load_bin8),
    .o_bin(bin8), .o_gray(gray8), .o_wrap(wrap8), .o_sat_hit(sath8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] lbin;
    logic       en;
    logic       up;
    logic       sat;
    logic [3:0] ebin;
    logic [3:0] egray;
    logic       ewrap;
    logic       esat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step4(input logic r, input logic l, input logic [3:0] lb,
                       input logic e, input logic u, input logic s);
    rst = r; load = l; load_bin = lb; en = e; up = u; sat = s;
    @(posedge clk);
    #1;
  endtask

  // Gray sequence of a 4-bit up count from 0 through the wrap back to 0.
  logic [3:0] gseq [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                            4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    logic [3:0] prev_gray;
    logic [7:0] mb, mg, pg;
    logic       mwrap, msat, counted;

    rst = 1'b1; load = 1'b0; load_bin = '0; en = 1'b0; up = 1'b1; sat = 1'b0;
    rst8 = 1'b1; load8 = 1'b0; load_bin8 = '0; en8 = 1'b0; up8 = 1'b1; sat8 = 1'b0;

    // Reset state
    step4(1, 0, 4'd0, 0, 1, 0);
    chk("reset_bin", 32'(bin4), 32'd0);
    chk("reset_gray", 32'(gray4), 32'd0);
    chk("reset_wrap", 32'(wrap4), 32'd0);
    chk("reset_sat", 32'(sath4), 32'd0);

    // Full up count through the wrap
    prev_gray = gray4;
    for (int i = 1; i < 17; i++) begin
      step4(0, 0, 4'd0, 1, 1, 0);
      chk($sformatf("up_gray[%0d]", i), 32'(gray4), 32'(gseq[i]));
      chk($sformatf("up_bin[%0d]", i), 32'(bin4), 32'(i % 16));
      chk($sformatf("up_wrap[%0d]", i), 32'(wrap4), (i == 16) ? 32'd1 : 32'd0);
      chk($sformatf("up_onebit[%0d]", i), 32'($countones(prev_gray ^ gray4)), 32'd1);
      prev_gray = gray4;
    end

    //            rst   load  lbin   en    up    sat   bin    gray      wrap  sat
    vecs.push_back('{1'b0, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 4'd2,  4'b0011, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd1,  4'b0001, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd15, 4'b1000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 4'd5,  4'b0111, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd0,  4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd1,  4'b0001, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd2,  4'b0011, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd3,  4'b0010, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd4,  4'b0110, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd5,  4'b0111, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd6,  4'b0101, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 4'd0,  4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd1,  4'b0001, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd1,  4'b0001, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd2,  4'b0011, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 4'd0,  4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0,  4'b0000, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd15, 4'b1000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  4'b0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd15, 4'b1000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0,  4'b0000, 1'b0, 1'b0});

    foreach (vecs[k]) begin
      step4(vecs[k].rst, vecs[k].load, vecs[k].lbin, vecs[k].en, vecs[k].up, vecs[k].sat);
      chk($sformatf("vec%0d_bin", k), 32'(bin4), 32'(vecs[k].ebin));
      chk($sformatf("vec%0d_gray", k), 32'(gray4), 32'(vecs[k].egray));
      chk($sformatf("vec%0d_wrap", k), 32'(wrap4), 32'(vecs[k].ewrap));
      chk($sformatf("vec%0d_sat", k), 32'(sath4), 32'(vecs[k].esat));
    end

    // WIDTH=8 random run against a behavioural model
    @(posedge clk);
    #1;
    mb = 8'd0;
    pg = gray8;
    chk("w8_reset_bin", 32'(bin8), 32'd0);
    for (int c = 0; c < 10000; c++) begin
      rst8      = ($urandom_range(0, 199) == 0);
      load8     = ($urandom_range(0, 19) == 0);
      load_bin8 = 8'($urandom_range(0, 255));
      en8       = ($urandom_range(0, 3) != 0);
      up8       = $urandom_range(0, 1) != 0;
      sat8      = $urandom_range(0, 1) != 0;
      if (c % 500 < 4) load_bin8 = (c % 2 == 0) ? 8'd255 : 8'd0;
      mwrap = 1'b0; msat = 1'b0; counted = 1'b0;
      if (rst8) begin
        mb = 8'd0;
      end else if (load8) begin
        mb = load_bin8;
      end else if (en8) begin
        if (up8 && mb == 8'd255) begin
          if (sat8) msat = 1'b1; else begin mb = 8'd0; mwrap = 1'b1; counted = 1'b1; end
        end else if (!up8 && mb == 8'd0) begin
          if (sat8) msat = 1'b1; else begin mb = 8'd255; mwrap = 1'b1; counted = 1'b1; end
        end else begin
          mb = up8 ? 8'(int'(mb) + 1) : 8'(int'(mb) - 1);
          counted = 1'b1;
        end
      end
      mg = mb ^ {1'b0, mb[7:1]};
      @(posedge clk);
      #1;
      chk("w8_bin", 32'(bin8), 32'(mb));
      chk("w8_gray", 32'(gray8), 32'(mg));
      chk("w8_wrap", 32'(wrap8), 32'(mwrap));
      chk("w8_sat", 32'(sath8), 32'(msat));
      if (counted) chk("w8_onebit", 32'($countones(pg ^ gray8)), 32'd1);
      if (msat) chk("w8_hold", 32'(pg), 32'(gray8));
      pg = gray8;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised, registered Gray-code up/down counter, the sequential successor to the team's combinational Gray/binary translator. It holds a binary count, presents it together with its Gray-code equivalent on registered outputs, and supports synchronous load, direction control and a wrap-or-saturate mode. Status pulses report wrap and saturation events. It drives hex/segment decoders directly and feeds downstream logic that needs single-bit-change count sequences, such as FIFO pointers.

## Interface
- WIDTH, 4, count width in bits; legal range 2..32.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  count enable; steps the count by one per cycle while high.
- i_up  in  1  direction: 1 = increment, 0 = decrement; sampled only when i_en=1.
- i_sat  in  1  limit mode: 0 = wrap at the ends, 1 = saturate at the ends.
- i_load  in  1  synchronous load strobe.
- i_load_bin  in  WIDTH  binary value to load.
- o_bin  out  WIDTH  registered binary count.
- o_gray  out  WIDTH  registered Gray code of o_bin: o_bin ^ (o_bin >> 1).
- o_wrap  out  1  one-cycle pulse: the count wrapped on the last edge.
- o_sat_hit  out  1  one-cycle pulse: a step was blocked at a limit on the last edge.

## Operation
- Internal state is a WIDTH-bit binary register B. o_bin = B.
- o_gray is a separate register loaded with f(next B) on the same edge as B, so o_bin and o_gray are always mutually consistent. It is never derived combinationally from o_bin.
- MAX = 2^WIDTH − 1 and MIN = 0. Arithmetic is unsigned, modulo 2^WIDTH.
- Per-edge priority: i_rst > i_load > i_en > hold.
- Reset: B=0, o_gray=0, o_wrap=0, o_sat_hit=0.
- Load: B ← i_load_bin and o_gray ← Gray(i_load_bin). i_en and i_up are ignored that cycle. o_wrap=0 and o_sat_hit=0.
- Count up, i_en=1 and i_up=1:
  - B<MAX: B ← B+1.
  - B=MAX with i_sat=0: B ← 0 and o_wrap=1.
  - B=MAX with i_sat=1: B holds and o_sat_hit=1.
- Count down, i_en=1 and i_up=0:
  - B>0: B ← B−1.
  - B=0 with i_sat=0: B ← MAX and o_wrap=1.
  - B=0 with i_sat=1: B holds and o_sat_hit=1.
- Idle, i_en=0 and i_load=0: B holds and both pulses are 0.
- i_sat and i_up may change on any cycle. Only values sampled on the current edge matter.
- Invariant: every non-load, non-reset step changes o_gray in exactly one bit position. This includes the wrap steps, because Gray(MAX) = 1 followed by zeros, and Gray(0) = 0.
- Held cycles, including saturation, change no output bit except the pulses.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency: an input sampled on edge N is visible on all outputs after edge N.
- o_wrap and o_sat_hit are high for exactly one cycle per event. Back-to-back events produce a continuously high pulse, one cycle per event. Example: WIDTH=2 with i_sat=1 held at the limit keeps o_sat_hit high every cycle.
- Reset mid-count: the next edge forces all outputs to the reset values regardless of i_load or i_en. Counting resumes from 0 on the first edge after i_rst falls.
- Load coincident with a would-be wrap or saturation: the load wins and no pulse is produced.

## Test plan
- Reset, then hold i_en=1, i_up=1, i_sat=0 for 17 cycles (WIDTH=4):
  - o_gray follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - o_wrap pulses only on the 1000→0000 step.
  - Exactly one o_gray bit changes per step.
- Load 4'd2, then count down for 3 cycles with i_sat=0:
  - o_bin goes 2,1,0,15.
  - o_gray goes 0011,0001,0000,1000.
  - o_wrap is high only after the 0→15 step.
- Load 4'd15 with i_sat=1, then count up for 3 cycles:
  - o_bin stays 15 and o_gray stays 1000.
  - o_sat_hit is high for all 3 cycles.
  - o_wrap stays 0.
- At B=15, assert i_load=1 with i_load_bin=4'd5 and i_en=1, i_up=1 together:
  - o_bin=5 and o_gray=0111.
  - No pulse on either status output.
- Count up from 0 to 6, then assert i_rst together with i_load=1 and i_en=1:
  - Next edge gives o_bin=0, o_gray=0, and both pulses 0.
  - The following enabled edge gives o_bin=1.
- WIDTH=8, randomised i_en, i_up, i_sat and i_load for 10k cycles, checked against a reference model:
  - o_gray always equals o_bin ^ (o_bin >> 1).
  - Every counting step changes exactly one Gray bit.
